// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_pkg;

    // Two-bit encoding so a corrupted state is detectable and recoverable.
    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit after ptr, wrapping, ptr itself last.
module rr_pick
    import wrr_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] masked;

    // Duplicate req and keep only the window ptr+1 .. ptr+NREQ of the doubled vector.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int j = 0; j < 2*NREQ; j++) begin
            masked[j] = dbl[j] && (j > int'(ptr)) && (j <= int'(ptr) + NREQ);
        end
    end

    // Lowest set bit of the window wins; fold its position back into 0..NREQ-1.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = 2*NREQ-1; j >= 0; j--) begin
            if (masked[j]) begin
                found = 1'b1;
                idx   = (j >= NREQ) ? IW'(j - NREQ) : IW'(j);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each holder keeps the grant for up to its quantum.
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WW   = 4,
    parameter int IW   = id_w(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*WW-1:0] weight,
    output logic [NREQ-1:0]    grant,
    output logic [IW-1:0]      grant_id,
    output logic               grant_valid,
    output logic               grant_last
);

    state_t          state;
    logic [WW-1:0]   cnt;
    logic [WW-1:0]   q;
    logic [IW-1:0]   ptr;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [WW-1:0]   pick_w;
    logic [WW-1:0]   pick_q;
    logic            hold_req;
    logic            at_end;

    // ptr always equals the last holder, so the same search serves idle and rotation.
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Quantum of the candidate, with a zero weight promoted to one cycle.
    always_comb begin
        pick_w   = weight[int'(pick_idx)*WW +: WW];
        pick_q   = (pick_w == '0) ? WW'(1) : pick_w;
        hold_req = req[grant_id];
        at_end   = (cnt == q - WW'(1));
    end

    assign grant_valid = |grant;
    assign grant_last  = grant_valid && at_end;

    // Grant state machine: hold while requested and quantum remains, else rotate or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            cnt      <= '0;
            q        <= WW'(1);
            ptr      <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE, GRANT: begin
                    if (state == GRANT && hold_req && !at_end) begin
                        cnt <= cnt + WW'(1);
                    end else if (pick_found) begin
                        state    <= GRANT;
                        grant    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                        grant_id <= pick_idx;
                        ptr      <= pick_idx;
                        cnt      <= '0;
                        q        <= pick_q;
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
                        grant_id <= '0;
                        cnt      <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    grant_id <= '0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed vector table, reset corner cases, random run vs model.
module tb_wrr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req4;
    logic [15:0] weight4;
    logic [3:0]  grant4;
    logic [1:0]  id4;
    logic        valid4, last4;

    logic        rst5;
    logic [4:0]  req5;
    logic [19:0] weight5;
    logic [4:0]  grant5;
    logic [2:0]  id5;
    logic        valid5, last5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wrr_arbiter #(.NREQ(4), .WW(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .weight(weight4),
        .grant(grant4), .grant_id(id4), .grant_valid(valid4), .grant_last(last4)
    );

    wrr_arbiter #(.NREQ(5), .WW(4)) dut5 (
        .clk(clk), .rst(rst5), .req(req5), .weight(weight5),
        .grant(grant5), .grant_id(id5), .grant_valid(valid5), .grant_last(last5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        bit          do_rst;
        logic [3:0]  req;
        logic [15:0] weight;
        logic [3:0]  grant;
        logic        last;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] rq, logic [15:0] w, logic [3:0] g, logic l);
        vec_t v;
        v.do_rst = r; v.req = rq; v.weight = w; v.grant = g; v.last = l;
        return v;
    endfunction

    function automatic logic [1:0] oh2id(input logic [3:0] g);
        logic [1:0] r = '0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic reset4();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Reference model for the 5-way instance: holder, cycles used, quantum, last holder.
    int m_hold  = -1;
    int m_used  = 0;
    int m_quant = 1;
    int m_last  = 4;
    int waitc[5];

    task automatic model_step(input logic [4:0] r, input logic [19:0] w);
        bit found;
        int c;
        int wv;
        if (m_hold >= 0 && r[m_hold] && m_used < m_quant) begin
            m_used++;
        end else begin
            found = 0;
            for (int k = 1; k <= 5; k++) begin
                c = (m_last + k) % 5;
                if (!found && r[c]) begin
                    found   = 1;
                    m_hold  = c;
                    m_last  = c;
                    m_used  = 1;
                    wv      = int'(w[c*4 +: 4]);
                    m_quant = (wv == 0) ? 1 : wv;
                end
            end
            if (!found) begin
                m_hold = -1;
                m_used = 0;
            end
        end
    endtask

    initial begin
        logic [4:0] eg;
        rst = 1'b0; req4 = '0; weight4 = '0;
        rst5 = 1'b0; req5 = '0; weight5 = '0;
        #1;
        chk("reset_grant", 32'(grant4), 0);
        chk("reset_id", 32'(id4), 0);
        chk("reset_valid", 32'(valid4), 0);
        chk("reset_last", 32'(last4), 0);
        @(negedge clk);
        rst = 1'b1;
        rst5 = 1'b1;

        // Full rotation, unit weights
        vecs.push_back(mk(0, 4'b1111, 16'h1111, 4'b0001, 1));
        vecs.push_back(mk(0, 4'b1111, 16'h1111, 4'b0010, 1));
        vecs.push_back(mk(0, 4'b1111, 16'h1111, 4'b0100, 1));
        vecs.push_back(mk(0, 4'b1111, 16'h1111, 4'b1000, 1));
        vecs.push_back(mk(0, 4'b1111, 16'h1111, 4'b0001, 1));
        // Weighted alternation 0 (q=3) and 2 (q=2)
        for (int rep = 0; rep < 2; rep++) begin
            vecs.push_back(mk(rep == 0, 4'b0101, 16'h0203, 4'b0001, 0));
            vecs.push_back(mk(0, 4'b0101, 16'h0203, 4'b0001, 0));
            vecs.push_back(mk(0, 4'b0101, 16'h0203, 4'b0001, 1));
            vecs.push_back(mk(0, 4'b0101, 16'h0203, 4'b0100, 0));
            vecs.push_back(mk(0, 4'b0101, 16'h0203, 4'b0100, 1));
        end
        // Early release hands over with no gap
        vecs.push_back(mk(1, 4'b1010, 16'h0040, 4'b0010, 0));
        vecs.push_back(mk(0, 4'b1010, 16'h0040, 4'b0010, 0));
        vecs.push_back(mk(0, 4'b1000, 16'h0040, 4'b1000, 1));
        // Release to nobody goes idle
        vecs.push_back(mk(0, 4'b0000, 16'h0040, 4'b0000, 0));
        // Zero weight sole requester
        for (int i = 0; i < 4; i++) vecs.push_back(mk(i == 0, 4'b0100, 16'h0000, 4'b0100, 1));
        // Weight change mid-grant does not alter quantum; resampled on re-grant
        vecs.push_back(mk(1, 4'b0001, 16'h0002, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0001, 16'h0005, 4'b0001, 1));
        vecs.push_back(mk(0, 4'b0001, 16'h0001, 4'b0001, 1));

        foreach (vecs[n]) begin
            @(negedge clk);
            if (vecs[n].do_rst) reset4();
            req4 = vecs[n].req;
            weight4 = vecs[n].weight;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_grant", n), 32'(grant4), 32'(vecs[n].grant));
            chk($sformatf("vec%0d_last", n), 32'(last4), 32'(vecs[n].last));
            chk($sformatf("vec%0d_id", n), 32'(id4), 32'(oh2id(vecs[n].grant)));
            chk($sformatf("vec%0d_valid", n), 32'(valid4), 32'(vecs[n].grant != 0));
        end

        // Asynchronous reset mid-quantum, then post-reset priority
        @(negedge clk);
        reset4();
        weight4 = 16'h0040;
        req4 = 4'b0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_hold_grant", 32'(grant4), 32'b0010);
        chk("mid_hold_last", 32'(last4), 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant4), 0);
        chk("async_rst_valid", 32'(valid4), 0);
        chk("async_rst_id", 32'(id4), 0);
        @(negedge clk);
        rst = 1'b1;
        req4 = 4'b1010;
        @(posedge clk); #1;
        chk("post_rst_grant", 32'(grant4), 32'b0010);

        // Random run on the 5-way instance
        for (int i = 0; i < 5; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) if ($urandom_range(5, 0) == 0) req5[i] = ~req5[i];
            weight5 = 20'($urandom);
            @(posedge clk);
            model_step(req5, weight5);
            #1;
            eg = (m_hold >= 0) ? (5'b00001 << m_hold) : 5'b00000;
            chk("rnd_grant", 32'(grant5), 32'(eg));
            chk("rnd_last", 32'(last5), 32'(m_hold >= 0 && m_used == m_quant));
            chk("rnd_id", 32'(id5), 32'((m_hold >= 0) ? m_hold : 0));
            chk("rnd_onehot", 32'($countones(grant5) <= 1), 1);
            for (int i = 0; i < 5; i++) begin
                if (req5[i] && !grant5[i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > 4*15) chk("rnd_starve", 32'(waitc[i]), 60);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
